// File: rtl/vga_window_stream.sv
// VGA raster generator with a positioned image window fetched from a synchronous pixel RAM.
// Sync, blank and colour are delayed to match the RAM read latency so they leave aligned.
module vga_window_stream #(
    parameter int          HDISP    = 640,
    parameter int          HFP      = 16,
    parameter int          HPULSE   = 96,
    parameter int          HBP      = 48,
    parameter int          VDISP    = 480,
    parameter int          VFP      = 10,
    parameter int          VPULSE   = 2,
    parameter int          VBP      = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int          IMG_X0   = 0,
    parameter int          IMG_Y0   = 0,
    parameter int          IMG_W    = 256,
    parameter int          IMG_H    = 256,
    parameter int          RAM_LAT  = 1,
    parameter int          RGB_MODE = 0,
    parameter logic [23:0] BG_COLOR = 24'h000000,
    localparam int         HTOT     = HDISP + HFP + HPULSE + HBP,
    localparam int         VTOT     = VDISP + VFP + VPULSE + VBP,
    localparam int         AW       = (IMG_W * IMG_H > 1) ? $clog2(IMG_W * IMG_H) : 1,
    localparam int         DW       = (RGB_MODE != 0) ? 24 : 8
) (
    input  logic          VGA_CLK,
    input  logic          rst_intern,
    input  logic          VGA_EN,
    input  logic [DW-1:0] RAM_DATA,
    output logic [AW-1:0] RAM_ADDR,
    output logic          VGA_HS,
    output logic          VGA_VS,
    output logic          VGA_BLANK,
    output logic          VGA_SYNC,
    output logic [7:0]    VGA_R,
    output logic [7:0]    VGA_G,
    output logic [7:0]    VGA_B,
    output logic          frame_start
);

    if (IMG_X0 + IMG_W > HDISP || IMG_Y0 + IMG_H > VDISP || RAM_LAT < 1) begin : g_bad_params
        $error("vga_window_stream: window outside active area or RAM_LAT < 1");
    end

    // One extra bit of headroom so every boundary up to HTOT/VTOT is representable.
    localparam int HW = $clog2(HTOT + 1);
    localparam int VW = $clog2(VTOT + 1);

    localparam logic [HW-1:0] H_LAST    = HW'(HTOT - 1);
    localparam logic [HW-1:0] H_DISP    = HW'(HDISP);
    localparam logic [HW-1:0] H_WIN_LO  = HW'(IMG_X0);
    localparam logic [HW-1:0] H_WIN_W   = HW'(IMG_W);
    localparam logic [HW-1:0] H_SYNC_LO = HW'(HDISP + HFP);
    localparam logic [HW-1:0] H_SYNC_W  = HW'(HPULSE);
    localparam logic [VW-1:0] V_LAST    = VW'(VTOT - 1);
    localparam logic [VW-1:0] V_DISP    = VW'(VDISP);
    localparam logic [VW-1:0] V_WIN_LO  = VW'(IMG_Y0);
    localparam logic [VW-1:0] V_WIN_H   = VW'(IMG_H);
    localparam logic [VW-1:0] V_SYNC_LO = VW'(VDISP + VFP);
    localparam logic [VW-1:0] V_SYNC_W  = VW'(VPULSE);

    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
        logic win;
        logic fs;
    } stage_t;

    logic [HW-1:0] hc;
    logic [VW-1:0] vc;
    logic [AW-1:0] addr;
    logic [HW-1:0] hx_win, hx_sync;
    logic [VW-1:0] vy_win, vy_sync;
    stage_t        raw;
    stage_t        pipe [RAM_LAT];
    stage_t        tail;
    logic [23:0]   pix_rgb;
    logic [23:0]   rgb_q;

    // Offsets wrap below the range start, so one unsigned compare covers both bounds.
    assign hx_win  = hc - H_WIN_LO;
    assign hx_sync = hc - H_SYNC_LO;
    assign vy_win  = vc - V_WIN_LO;
    assign vy_sync = vc - V_SYNC_LO;

    always_comb begin
        // NOTE: default every field first so no path leaves raw unassigned (no latch).
        raw     = '0;
        raw.hs  = VGA_EN && (hx_sync < H_SYNC_W);
        raw.vs  = VGA_EN && (vy_sync < V_SYNC_W);
        raw.act = VGA_EN && (hc < H_DISP) && (vc < V_DISP);
        raw.win = VGA_EN && (hx_win < H_WIN_W) && (vy_win < V_WIN_H);
        raw.fs  = VGA_EN && (hc == '0) && (vc == '0);
    end

    always_ff @(posedge VGA_CLK or posedge rst_intern) begin
        if (rst_intern) begin
            hc   <= '0;
            vc   <= '0;
            addr <= '0;
        end else if (!VGA_EN) begin
            hc   <= '0;
            vc   <= '0;
            addr <= '0;
        end else begin
            if (hc == H_LAST) begin
                hc <= '0;
                vc <= (vc == V_LAST) ? '0 : vc + VW'(1);
            end else begin
                hc <= hc + HW'(1);
            end
            if (hc == H_LAST && vc == V_LAST)
                addr <= '0;
            else if (raw.win)
                addr <= addr + AW'(1);
        end
    end

    assign RAM_ADDR = addr;

    // NOTE: the delay line is a small register chain, not a RAM, so it takes the async reset.
    always_ff @(posedge VGA_CLK or posedge rst_intern) begin
        if (rst_intern) begin
            for (int i = 0; i < RAM_LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= raw;
            for (int i = 1; i < RAM_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign tail = pipe[RAM_LAT-1];

    if (RGB_MODE != 0) begin : g_rgb
        assign pix_rgb = RAM_DATA;
    end else begin : g_grey
        assign pix_rgb = {3{RAM_DATA}};
    end

    always_ff @(posedge VGA_CLK or posedge rst_intern) begin
        if (rst_intern) begin
            VGA_HS      <= ~HS_POL;
            VGA_VS      <= ~VS_POL;
            VGA_BLANK   <= 1'b0;
            frame_start <= 1'b0;
            rgb_q       <= '0;
        end else begin
            VGA_HS      <= tail.hs ? HS_POL : ~HS_POL;
            VGA_VS      <= tail.vs ? VS_POL : ~VS_POL;
            VGA_BLANK   <= tail.act;
            frame_start <= tail.fs;
            if (!tail.act)
                rgb_q <= '0;
            else if (!tail.win)
                rgb_q <= BG_COLOR;
            else
                rgb_q <= pix_rgb;
        end
    end

    assign VGA_R    = rgb_q[23:16];
    assign VGA_G    = rgb_q[15:8];
    assign VGA_B    = rgb_q[7:0];
    assign VGA_SYNC = 1'b0;

endmodule

// File: tb/tb_vga_window_stream.sv
// Directed bench: a grey window DUT (RAM_LAT=2) and an RGB, inverted-polarity DUT (RAM_LAT=1).
// Output pixels are located by cycle count: raster index p appears at cycle p + L.
module tb_vga_window_stream;

    localparam int HTOT_A  = 344;
    localparam int VTOT_A  = 166;
    localparam int FRAME_A = HTOT_A * VTOT_A;
    localparam int L_A     = 3;
    localparam int HTOT_B  = 312;
    localparam int L_B     = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en_a = 1'b0;
    logic en_b = 1'b0;

    always #5 clk = ~clk;

    logic [7:0]  data_a;
    logic [23:0] data_b;
    logic [14:0] addr_a;
    logic [8:0]  addr_b;
    logic        hs_a, vs_a, blank_a, sync_a, fs_a;
    logic        hs_b, vs_b, blank_b, sync_b, fs_b;
    logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b;

    vga_window_stream #(
        .HDISP(328), .HFP(4), .HPULSE(8), .HBP(4),
        .VDISP(160), .VFP(2), .VPULSE(2), .VBP(2),
        .HS_POL(1'b0), .VS_POL(1'b0),
        .IMG_X0(64), .IMG_Y0(32), .IMG_W(256), .IMG_H(128),
        .RAM_LAT(2), .RGB_MODE(0), .BG_COLOR(24'h0A0B0C)
    ) dut_a (
        .VGA_CLK(clk), .rst_intern(rst), .VGA_EN(en_a), .RAM_DATA(data_a), .RAM_ADDR(addr_a),
        .VGA_HS(hs_a), .VGA_VS(vs_a), .VGA_BLANK(blank_a), .VGA_SYNC(sync_a),
        .VGA_R(r_a), .VGA_G(g_a), .VGA_B(b_a), .frame_start(fs_a)
    );

    vga_window_stream #(
        .HDISP(304), .HFP(2), .HPULSE(4), .HBP(2),
        .VDISP(104), .VFP(1), .VPULSE(2), .VBP(1),
        .HS_POL(1'b1), .VS_POL(1'b1),
        .IMG_X0(16), .IMG_Y0(8), .IMG_W(32), .IMG_H(15),
        .RAM_LAT(1), .RGB_MODE(1), .BG_COLOR(24'hFF0000)
    ) dut_b (
        .VGA_CLK(clk), .rst_intern(rst), .VGA_EN(en_b), .RAM_DATA(data_b), .RAM_ADDR(addr_b),
        .VGA_HS(hs_b), .VGA_VS(vs_b), .VGA_BLANK(blank_b), .VGA_SYNC(sync_b),
        .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b), .frame_start(fs_b)
    );

    // Two-cycle RAM returning the low address byte; the RGB DUT sees a constant word.
    logic [7:0] ram_q1;
    always @(posedge clk) begin
        ram_q1 <= addr_a[7:0];
        data_a <= ram_q1;
    end
    assign data_b = 24'h123456;

    int cyc_a, cyc_b;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_a <= 0;
            cyc_b <= 0;
        end else begin
            cyc_a <= en_a ? cyc_a + 1 : 0;
            cyc_b <= en_b ? cyc_b + 1 : 0;
        end
    end

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          dut;
        int          x;
        int          y;
        logic [23:0] rgb;
        logic [3:0]  ctl;   // {blank, hs, vs, frame_start}
        int          addr;  // RAM_ADDR at raster time, -1 = not checked
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int d, input int x, input int y, input logic [23:0] rgb,
                       input logic [3:0] ctl, input int addr);
        vec_t v;
        v.dut = d; v.x = x; v.y = y; v.rgb = rgb; v.ctl = ctl; v.addr = addr;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int cyc_of(input int d);
        return (d != 0) ? cyc_b : cyc_a;
    endfunction

    function automatic logic [23:0] rgb_of(input int d);
        return (d != 0) ? {r_b, g_b, b_b} : {r_a, g_a, b_a};
    endfunction

    function automatic logic [3:0] ctl_of(input int d);
        return (d != 0) ? {blank_b, hs_b, vs_b, fs_b} : {blank_a, hs_a, vs_a, fs_a};
    endfunction

    function automatic logic [31:0] addr_of(input int d);
        return (d != 0) ? 32'(addr_b) : 32'(addr_a);
    endfunction

    task automatic wait_to(input int d, input int target);
        int guard = 0;
        while (cyc_of(d) < target && guard < 100000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc_of(d) != target) begin
            total++;
            bad++;
            $display("FAIL wait dut%0d: cycle %0d, wanted %0d", d, cyc_of(d), target);
        end
    endtask

    task automatic run_table(input int d);
        int p, lat, htot;
        lat  = (d != 0) ? L_B : L_A;
        htot = (d != 0) ? HTOT_B : HTOT_A;
        foreach (vecs[i]) begin
            if (vecs[i].dut == d) begin
                p = vecs[i].y * htot + vecs[i].x;
                if (vecs[i].addr >= 0) begin
                    wait_to(d, p);
                    check($sformatf("dut%0d addr(%0d,%0d)", d, vecs[i].x, vecs[i].y),
                          addr_of(d), 32'(vecs[i].addr));
                end
                wait_to(d, p + lat);
                check($sformatf("dut%0d rgb(%0d,%0d)", d, vecs[i].x, vecs[i].y),
                      32'(rgb_of(d)), 32'(vecs[i].rgb));
                check($sformatf("dut%0d ctl(%0d,%0d)", d, vecs[i].x, vecs[i].y),
                      32'(ctl_of(d)), 32'(vecs[i].ctl));
            end
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, " a ctl"},  32'(ctl_of(0)), 32'b0110);
        check({tag, " a rgb"},  32'(rgb_of(0)), 32'h0);
        check({tag, " a addr"}, addr_of(0), 32'h0);
        check({tag, " b ctl"},  32'(ctl_of(1)), 32'b0000);
        check({tag, " b rgb"},  32'(rgb_of(1)), 32'h0);
        check({tag, " b addr"}, addr_of(1), 32'h0);
        check({tag, " sync"},   32'({sync_a, sync_b}), 32'h0);
    endtask

    task automatic branch_a();
        wait_to(0, L_A - 1);
        check("a first fs early", 32'(fs_a), 32'h0);
        run_table(0);
        wait_to(0, FRAME_A);
        check("a addr next frame", addr_of(0), 32'h0);
        wait_to(0, FRAME_A + L_A - 1);
        check("a fs2 early", 32'(fs_a), 32'h0);
        wait_to(0, FRAME_A + L_A);
        check("a fs2", 32'(fs_a), 32'h1);
    endtask

    task automatic branch_b();
        run_table(1);
        // Drop the enable while raster (300,100) is current.
        wait_to(1, 100 * HTOT_B + 300);
        en_b = 1'b0;
        @(negedge clk);
        check("b drain blank", 32'(ctl_of(1)), 32'b1000);
        check("b drain rgb", 32'(rgb_of(1)), 32'hFF0000);
        @(negedge clk);
        check("b off ctl", 32'(ctl_of(1)), 32'b0000);
        check("b off rgb", 32'(rgb_of(1)), 32'h0);
        check("b off addr", addr_of(1), 32'h0);
        repeat (48) @(negedge clk);
        check("b off ctl late", 32'(ctl_of(1)), 32'b0000);
        check("b off addr late", addr_of(1), 32'h0);
        en_b = 1'b1;
        @(negedge clk);
        check("b reen fs early", 32'(fs_b), 32'h0);
        @(negedge clk);
        check("b reen ctl", 32'(ctl_of(1)), 32'b1001);
        @(negedge clk);
        check("b reen fs after", 32'(fs_b), 32'h0);
        wait_to(1, 8 * HTOT_B + 17);
        check("b addr restart", addr_of(1), 32'h1);
        wait_to(1, 105 * HTOT_B + L_B);
        check("b vs pulse", 32'(ctl_of(1)), 32'b0010);
        wait_to(1, 107 * HTOT_B + L_B);
        check("b vs idle", 32'(ctl_of(1)), 32'b0000);
    endtask

    initial begin
        add(0,   0,   0, 24'h0A0B0C, 4'b1111, -1);
        add(0,  63,  32, 24'h0A0B0C, 4'b1110, -1);
        add(0,  64,  32, 24'h000000, 4'b1110, -1);
        add(0, 319,  32, 24'hFFFFFF, 4'b1110, -1);
        add(0, 320,  32, 24'h0A0B0C, 4'b1110, -1);
        add(0, 331,  32, 24'h000000, 4'b0110, -1);
        add(0, 332,  32, 24'h000000, 4'b0010, -1);
        add(0, 339,  32, 24'h000000, 4'b0010, -1);
        add(0, 340,  32, 24'h000000, 4'b0110, -1);
        add(0,  65,  33, 24'h010101, 4'b1110, 257);
        add(0, 100,  40, 24'h242424, 4'b1110, 2084);
        add(0, 319, 159, 24'hFFFFFF, 4'b1110, 32767);
        add(0,   0, 161, 24'h000000, 4'b0110, -1);
        add(0,   0, 162, 24'h000000, 4'b0100, -1);
        add(0,  10, 163, 24'h000000, 4'b0100, -1);
        add(0,   0, 164, 24'h000000, 4'b0110, -1);
        add(1,   0,   0, 24'hFF0000, 4'b1001, -1);
        add(1,  20,  10, 24'h123456, 4'b1000, 68);
        add(1,  47,  22, 24'h123456, 4'b1000, -1);
        add(1,  48,  22, 24'hFF0000, 4'b1000, -1);
        add(1, 303,  30, 24'hFF0000, 4'b1000, -1);
        add(1, 304,  30, 24'h000000, 4'b0000, -1);
        add(1, 306,  30, 24'h000000, 4'b0100, -1);
        add(1, 309,  30, 24'h000000, 4'b0100, -1);
        add(1, 310,  30, 24'h000000, 4'b0000, -1);

        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_reset("reset");
        rst  = 1'b0;
        en_a = 1'b1;
        en_b = 1'b1;

        fork
            branch_a();
            branch_b();
        join

        // Reset inside the window, between clock edges.
        wait_to(0, FRAME_A + 40 * HTOT_A + 100 + L_A);
        check("a pre-reset pixel", 32'(rgb_of(0)), 32'h242424);
        check("a pre-reset blank", 32'(blank_a), 32'h1);
        #1 rst = 1'b1;
        #1 check_reset("async reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_window_stream.md
# vga_window_stream

Parametrised VGA raster generator with a positioned image window fetched from an external synchronous pixel RAM. The block generates programmable sync timing with selectable polarity and a row-major linear RAM address for a window of any size and position. It compensates for a configurable RAM read latency so that sync, blank and colour leave the block aligned. The block sits between the frame-buffer RAM and the board DAC.

## Interface
- HDISP, 640: active pixels per line
- HFP / HPULSE / HBP, 16 / 96 / 48: horizontal front porch, sync, back porch (cycles)
- VDISP, 480: active lines
- VFP / VPULSE / VBP, 10 / 2 / 33: vertical front porch, sync, back porch (lines)
- HS_POL / VS_POL, 0 / 0: sync active level (0 = active-low)
- IMG_X0 / IMG_Y0, 0 / 0: window top-left corner, in pixels/lines
- IMG_W / IMG_H, 256 / 256: window size
- RAM_LAT, 1: RAM read latency in cycles (≥1)
- RGB_MODE, 0: 0 = 8-bit grey (R=G=B=data), 1 = 24-bit {R,G,B}
- BG_COLOR, 24'h000000: {R,G,B} colour driven outside the window inside the active area
- Derived: HTOT = HDISP+HFP+HPULSE+HBP; VTOT likewise; AW = $clog2(IMG_W*IMG_H); DW = RGB_MODE ? 24 : 8
- Elaboration error if IMG_X0+IMG_W > HDISP, IMG_Y0+IMG_H > VDISP, or RAM_LAT < 1

Ports:
- VGA_CLK  in  1  pixel clock
- rst_intern  in  1  reset, asynchronous, active-high
- VGA_EN  in  1  raster enable
- RAM_DATA  in  DW  pixel data, valid RAM_LAT cycles after RAM_ADDR
- RAM_ADDR  out  AW  linear window address
- VGA_HS / VGA_VS  out  1  syncs
- VGA_BLANK  out  1  1 = active video
- VGA_SYNC  out  1  constant 0
- VGA_R / VGA_G / VGA_B  out  8  colour
- frame_start  out  1  one-cycle pulse aligned with output pixel (0,0)

## Operation
- hc counts 0..HTOT-1 and wraps. vc increments when hc = HTOT-1 and wraps from VTOT-1 to 0 on that same cycle.
- VGA_EN = 0: hc, vc and the address counter are forced to 0 and held. The pipeline input stage is forced to blank=0, syncs inactive, in_window=0. On re-enable, the raster restarts at (0,0).
- in_win = (IMG_X0 ≤ hc < IMG_X0+IMG_W) && (IMG_Y0 ≤ vc < IMG_Y0+IMG_H).
- Address counter:
  - Cleared to 0 when hc = HTOT-1 and vc = VTOT-1.
  - Incremented by 1 (width AW) on each in_win cycle; otherwise held.
  - RAM_ADDR is driven directly from this register, so window pixel (x,y) maps to address y*IMG_W + x.
- Raw stage signals, computed from (hc, vc):
  - hs_act = HDISP+HFP ≤ hc < HDISP+HFP+HPULSE
  - vs_act = VDISP+VFP ≤ vc < VDISP+VFP+VPULSE
  - act = hc < HDISP && vc < VDISP
  - fs = (hc = 0 && vc = 0 && VGA_EN)
- Delay line: hs_act, vs_act, act, in_win and fs pass through RAM_LAT shift stages, then one output register.
- Output register:
  - VGA_HS = hs_act_d ? HS_POL : !HS_POL; VGA_VS likewise with VS_POL.
  - VGA_BLANK = act_d; frame_start = fs_d.
  - Colour: !act_d → 0; act_d && !in_win_d → BG_COLOR; act_d && in_win_d → RAM_DATA (grey replicated, or RGB split with R = [23:16]).

## Timing
- Latency L = RAM_LAT+1 from the raster state (hc,vc) to all outputs. Every output is registered and aligned with every other output.
- Reset values:
  - RAM_ADDR = 0; hc = vc = 0; all delay stages cleared.
  - VGA_HS = !HS_POL, VGA_VS = !VS_POL.
  - VGA_BLANK = 0, VGA_R/G/B = 0, frame_start = 0.
- Reset mid-frame clears everything asynchronously. The first frame_start appears L cycles after the first VGA_CLK edge with rst_intern low and VGA_EN high.
- Disable transition: after VGA_EN falls, outputs keep streaming already-fetched pixels for L cycles. From then on they are blank with syncs inactive.
- Window touching the line end (IMG_X0+IMG_W = HDISP) and a full-screen window must both map correctly. The address wraps to 0 only at the frame boundary.

## Test plan
- Defaults, RAM_LAT=1 (HTOT=800, VTOT=525):
  - HS low for 96 cycles starting at hc=656+2, period 800.
  - VS low during lines 490–491.
  - BLANK high for 640 cycles per line on lines 0–479.
  - frame_start every 420000 cycles.
- IMG_X0=64, IMG_Y0=32, IMG_W=256, IMG_H=128, RAM_LAT=2, RAM model returns addr[7:0]:
  - Output pixels (64,32) = 0x00, (319,32) = 0xFF, (65,33) = 0x01.
  - RAM_ADDR is 32767 at (319,159) and 0 at the next frame.
  - Pixels (63,32) and (320,32) = BG_COLOR.
- RGB_MODE=1, RAM_DATA=24'h123456 inside the window → R=0x12, G=0x34, B=0x56. BG_COLOR=24'hFF0000 outside the window → R=0xFF.
- HS_POL=1, VS_POL=1 → sync idle low, pulses high; reset levels low.
- Deassert VGA_EN at hc=300, vc=100 for 50 cycles:
  - Outputs blank with inactive syncs from L cycles after deassertion.
  - After re-enable, frame_start pulses exactly L cycles later and RAM_ADDR restarts at 0.
- Assert rst_intern mid-line inside the window → all outputs take their reset values immediately, without waiting for a clock edge.
